// File: rtl/switch_word_loader_pkg.sv
// Shared types and constants for the switch word loader: FSM states,
// bytes per word and the bit positions of the status LED fields.
package switch_word_loader_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // LED = {done, wr_valid, byte_cnt[1:0], wr_addr[3:0]}
  localparam int LED_DONE_BIT  = 7;
  localparam int LED_VALID_BIT = 6;
  localparam int LED_CNT_LSB   = 4;
  localparam int LED_ADDR_LSB  = 0;

endpackage

// File: rtl/switch_word_loader_key_edge.sv
// Registered rising-edge detector for one debounced key. The history register
// resets to 1 so a key held through reset does not produce a pulse.
module switch_word_loader_key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);

  logic key_q;

  always_ff @(posedge clk) begin
    if (rst) key_q <= 1'b1;
    else     key_q <= key;
  end

  assign pulse = key & ~key_q;

endmodule

// File: rtl/switch_word_loader.sv
// Assembles 32-bit words from four switch bytes and writes them to memory.
// Optional feature: define LOADER_CHECKSUM_EN for a running XOR of accepted bytes.
module switch_word_loader
  import switch_word_loader_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic [7:0]        sw,
  input  logic              key_load,
  input  logic              key_abort,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              done,
  output logic [7:0]        LED,
  output logic [1:0]        state_dbg
);

  localparam logic [ADDR_W:0] CAPACITY  = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [1:0]      LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t              state, state_n;
  logic [1:0]          byte_cnt, byte_cnt_n;
  logic [31:0]         data, data_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [ADDR_W:0]     word_cnt, word_cnt_n;
  logic                load_pulse, abort_pulse;
  logic [3:0]          led_addr;
  logic [7:0]          status;

  switch_word_loader_key_edge u_load_edge (
    .clk   (clka),
    .rst   (rsta),
    .key   (key_load),
    .pulse (load_pulse)
  );

  switch_word_loader_key_edge u_abort_edge (
    .clk   (clka),
    .rst   (rsta),
    .key   (key_abort),
    .pulse (abort_pulse)
  );

  always_ff @(posedge clka) begin
    if (rsta) begin
      state    <= COLLECT;
      byte_cnt <= '0;
      data     <= '0;
      wr_addr  <= ADDR_W'(BASE_ADDR);
      word_cnt <= '0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_cnt_n;
      data     <= data_n;
      wr_addr  <= addr_n;
      word_cnt <= word_cnt_n;
    end
  end

  // Write handshake: wr_valid is high for the whole WRITE state, wr_addr and
  // wr_data do not change while it is high, and the word transfers on the
  // first cycle with wr_valid & wr_ready. wr_ready alone does nothing.
  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    data_n     = data;
    addr_n     = wr_addr;
    word_cnt_n = word_cnt;
    case (state)
      COLLECT: begin
        if (abort_pulse) begin
          data_n     = '0;
          byte_cnt_n = '0;
        end else if (load_pulse) begin
          data_n = {sw, data[31:8]};
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_n = '0;
            state_n    = WRITE;
          end else begin
            byte_cnt_n = byte_cnt + 2'd1;
          end
        end
      end
      WRITE: begin
        if (wr_ready) begin
          addr_n     = wr_addr + ADDR_W'(1);
          word_cnt_n = word_cnt + (ADDR_W+1)'(1);
          data_n     = '0;
          state_n    = (word_cnt_n == CAPACITY) ? DONE : COLLECT;
        end
      end
      DONE: begin
      end
      default: state_n = COLLECT;
    endcase
  end

  assign wr_valid  = (state == WRITE);
  assign done      = (state == DONE);
  assign wr_data   = data;
  assign state_dbg = state;

  generate
    if (ADDR_W >= 4) begin : g_addr_wide
      assign led_addr = wr_addr[3:0];
    end else begin : g_addr_narrow
      assign led_addr = {{(4-ADDR_W){1'b0}}, wr_addr};
    end
  endgenerate

  always_comb begin
    status                               = '0;
    status[LED_DONE_BIT]                 = done;
    status[LED_VALID_BIT]                = wr_valid;
    status[LED_CNT_LSB +: 2]             = byte_cnt;
    status[LED_ADDR_LSB +: 4]            = led_addr;
  end

`ifdef LOADER_CHECKSUM_EN
  // Only reset clears the checksum; abort leaves already-XORed bytes in place.
  logic [7:0] checksum;

  always_ff @(posedge clka) begin
    if (rsta)
      checksum <= '0;
    else if (state == COLLECT && load_pulse && !abort_pulse)
      checksum <= checksum ^ sw;
  end

  assign LED = key_abort ? checksum : status;
`else
  assign LED = status;
`endif

endmodule

// File: tb/tb_switch_word_loader.sv
// Directed bench for switch_word_loader: byte assembly, handshake stalls,
// abort, key edge detection, capacity/done and reset behaviour.
module tb_switch_word_loader;

  logic        clka = 1'b0;
  logic        rsta;
  logic [7:0]  sw;
  logic        key_load;
  logic        key_abort;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        done;
  logic [7:0]  LED;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];

  switch_word_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut (
    .clka      (clka),
    .rsta      (rsta),
    .sw        (sw),
    .key_load  (key_load),
    .key_abort (key_abort),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done),
    .LED       (LED),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clka = ~clka;

  task automatic apply_reset(input int cycles);
    @(negedge clka);
    rsta = 1'b1;
    repeat (cycles) @(negedge clka);
    rsta = 1'b0;
  endtask

  // checking
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // drivers: inputs change on the falling edge, outputs are sampled there too
  task automatic press_load(input logic [7:0] b);
    @(negedge clka);
    sw       = b;
    key_load = 1'b1;
    @(negedge clka);
    key_load = 1'b0;
  endtask

  task automatic press_abort();
    @(negedge clka);
    key_abort = 1'b1;
    @(negedge clka);
    key_abort = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back({b3, b2, b1, b0});
    press_load(b0);
    press_load(b1);
    press_load(b2);
    press_load(b3);
  endtask

  // Called on the cycle wr_valid is expected high; pops the scoreboard.
  task automatic check_write(input string tag, input logic [3:0] addr);
    logic [31:0] exp_word;
    exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_valid"}, {31'd0, wr_valid}, 32'd1);
    check({tag, "_data"},  wr_data, exp_word);
    check({tag, "_addr"},  {28'd0, wr_addr}, {28'd0, addr});
  endtask

  initial begin
    rsta      = 1'b1;
    sw        = 8'h00;
    key_load  = 1'b0;
    key_abort = 1'b0;
    wr_ready  = 1'b0;
    repeat (3) @(negedge clka);
    rsta = 1'b0;

    // reset state
    check("rst_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_data",  wr_data, 32'd0);
    check("rst_addr",  {28'd0, wr_addr}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_led",   {24'd0, LED}, 32'h00);

    // basic word, memory always ready
    wr_ready = 1'b1;
    load_word(8'h78, 8'h56, 8'h34, 8'h12);
    check_write("w0", 4'd0);
    check("w0_led_busy", {24'd0, LED}, 32'h40);
    @(negedge clka);
    check("w0_valid_drop", {31'd0, wr_valid}, 32'd0);
    check("w0_addr_next",  {28'd0, wr_addr}, 32'd1);
    check("w0_led_after",  {24'd0, LED}, 32'h01);

    // stalled handshake with load presses while waiting
    wr_ready = 1'b0;
    load_word(8'h78, 8'h56, 8'h34, 8'h12);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, wr_valid}, 32'd1);
      check("stall_data",  wr_data, 32'h1234_5678);
      check("stall_addr",  {28'd0, wr_addr}, 32'd1);
      sw       = 8'hFF;
      key_load = (i % 2 == 0);
      @(negedge clka);
    end
    key_load = 1'b0;
    check_write("w1", 4'd1);
    wr_ready = 1'b1;
    @(negedge clka);
    check("w1_valid_drop", {31'd0, wr_valid}, 32'd0);
    check("w1_led_after",  {24'd0, LED}, 32'h02);

    // abort discards a partial word
    press_load(8'hAA);
    press_load(8'hBB);
    check("abort_led_before", {24'd0, LED}, 32'h22);
    press_abort();
    check("abort_led_after", {24'd0, LED}, 32'h02);
    load_word(8'h01, 8'h02, 8'h03, 8'h04);
    check_write("w2", 4'd2);
    @(negedge clka);
    check("w2_addr_next", {28'd0, wr_addr}, 32'd3);

    // abort and load in the same cycle: abort wins
    press_load(8'h55);
    check("both_led_before", {24'd0, LED}, 32'h13);
    @(negedge clka);
    sw        = 8'h66;
    key_load  = 1'b1;
    key_abort = 1'b1;
    @(negedge clka);
    key_load  = 1'b0;
    key_abort = 1'b0;
    check("both_led_after", {24'd0, LED}, 32'h03);
    load_word(8'h11, 8'h22, 8'h33, 8'h44);
    check_write("w3", 4'd3);
    @(negedge clka);

    // long hold gives one byte only
    @(negedge clka);
    sw       = 8'h9A;
    key_load = 1'b1;
    repeat (20) @(negedge clka);
    key_load = 1'b0;
    @(negedge clka);
    check("hold_led", {24'd0, LED}, 32'h14);
    check("hold_data", wr_data, 32'h9A00_0000);

    // reset mid-word with load held through reset release
    key_load = 1'b1;
    apply_reset(3);
    repeat (5) @(negedge clka);
    key_load = 1'b0;
    @(negedge clka);
    check("rstheld_led",  {24'd0, LED}, 32'h00);
    check("rstheld_data", wr_data, 32'd0);

    // fill capacity
    for (int w = 0; w < 16; w++) begin
      logic [7:0] wb;
      wb = 8'(w);
      load_word(wb, 8'hA0 | wb, 8'h50, 8'hC3);
      check_write("fill", wb[3:0]);
      @(negedge clka);
    end
    check("full_done", {31'd0, done}, 32'd1);
    check("full_led",  {24'd0, LED}, 32'h80);
    check("full_state", {30'd0, state_dbg}, 32'd2);
    press_load(8'h01);
    press_load(8'h02);
    press_load(8'h03);
    press_load(8'h04);
    @(negedge clka);
    check("full_no_write", {31'd0, wr_valid}, 32'd0);
    check("full_led_hold", {24'd0, LED}, 32'h80);
    apply_reset(2);
    check("full_rst_addr", {28'd0, wr_addr}, 32'd0);
    check("full_rst_done", {31'd0, done}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    load_word(8'h0F, 8'hF0, 8'h33, 8'h00);
    check_write("csum_w", 4'd0);
    @(negedge clka);
    key_abort = 1'b1;
    #1;
    check("csum_led", {24'd0, LED}, 32'hCC);
    @(negedge clka);
    key_abort = 1'b0;
    #1;
    check("csum_led_status", {24'd0, LED}, 32'h01);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
